// File: rtl/hpb_wr_sched.sv
// Host write scheduler: buffers host writes and hands them to the RAM control
// block one at a time over the hpb_wr_req / rcb_wr_done handshake.
module hpb_wr_sched #(
    parameter int unsigned RAM_WIDTH    = 64,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   host_wr_valid,
    output logic                   host_wr_ready,
    input  logic [13:0]            host_wr_addr,
    input  logic [RAM_WIDTH-1:0]   host_wr_data,
    input  logic [RAM_WIDTH/8-1:0] host_wr_be,
    output logic                   hpb_wr_req,
    output logic [13:0]            hpb_wr_addr,
    output logic [RAM_WIDTH-1:0]   hpb_wr_data,
    output logic [RAM_WIDTH/8-1:0] hpb_wr_en,
    input  logic                   rcb_wr_done,
    output logic                   sched_starve,
    output logic                   sched_busy,
    output logic [15:0]            sched_wr_count
);

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned BE_W   = RAM_WIDTH / 8;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [RAM_WIDTH-1:0] data;
        logic [BE_W-1:0]      be;
    } wr_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    wr_entry_t             mem_q [FIFO_DEPTH];
    wr_entry_t             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  req_q, req_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [RAM_WIDTH-1:0]  data_q, data_d;
    logic [BE_W-1:0]       en_q, en_d;
    logic                  starve_q, starve_d;
    logic                  busy_q, busy_d;
    logic [15:0]           wr_count_q, wr_count_d;
    logic                  push;
    logic                  pop;
    wr_entry_t             head;

    // FIFO bookkeeping: push when ready, pop when the FSM loads the head in IDLE
    always_comb begin
        host_wr_ready = (cnt_q != CNT_W'(FIFO_DEPTH));
        push          = host_wr_valid && host_wr_ready;
        pop           = (state_q == ST_IDLE) && (cnt_q != CNT_W'(0));
        head          = mem_q[rd_ptr_q];
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cnt_d         = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{addr: host_wr_addr, data: host_wr_data, be: host_wr_be};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Scheduler FSM: next state, request outputs, wait counter, completion count
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        req_d      = req_q;
        addr_d     = addr_q;
        data_d     = data_q;
        en_d       = en_q;
        starve_d   = starve_q;
        wr_count_d = wr_count_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    addr_d  = head.addr;
                    data_d  = head.data;
                    en_d    = head.be;
                    req_d   = 1'b1;
                    wait_d  = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                req_d = 1'b1;
                if (rcb_wr_done) begin
                    req_d      = 1'b0;
                    starve_d   = 1'b0;
                    wr_count_d = wr_count_q + 16'd1;
                    state_d    = ST_GAP;
                end else begin
                    if (wait_q != WAIT_W'(STARVE_LIMIT)) begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                    if (wait_q == WAIT_W'(STARVE_LIMIT)) begin
                        starve_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                // One request-low cycle so the RAM block can re-arm
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (cnt_d != CNT_W'(0)) || (state_d != ST_IDLE);
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            en_q       <= '0;
            starve_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_count_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            wait_q     <= wait_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            en_q       <= en_d;
            starve_q   <= starve_d;
            busy_q     <= busy_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign hpb_wr_req     = req_q;
    assign hpb_wr_addr    = addr_q;
    assign hpb_wr_data    = data_q;
    assign hpb_wr_en      = en_q;
    assign sched_starve   = starve_q;
    assign sched_busy     = busy_q;
    assign sched_wr_count = wr_count_q;

endmodule

// File: tb/tb_hpb_wr_sched.sv
// Directed self-checking bench for hpb_wr_sched (default parameters).
module tb_hpb_wr_sched;

    localparam int unsigned RAM_WIDTH = 64;
    localparam int unsigned BE_W      = RAM_WIDTH / 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 host_wr_valid;
    logic                 host_wr_ready;
    logic [13:0]          host_wr_addr;
    logic [RAM_WIDTH-1:0] host_wr_data;
    logic [BE_W-1:0]      host_wr_be;
    logic                 hpb_wr_req;
    logic [13:0]          hpb_wr_addr;
    logic [RAM_WIDTH-1:0] hpb_wr_data;
    logic [BE_W-1:0]      hpb_wr_en;
    logic                 rcb_wr_done;
    logic                 sched_starve;
    logic                 sched_busy;
    logic [15:0]          sched_wr_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [15:0] exp_cnt;

    hpb_wr_sched #(.RAM_WIDTH(RAM_WIDTH), .FIFO_DEPTH(4), .STARVE_LIMIT(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .host_wr_be    (host_wr_be),
        .hpb_wr_req    (hpb_wr_req),
        .hpb_wr_addr   (hpb_wr_addr),
        .hpb_wr_data   (hpb_wr_data),
        .hpb_wr_en     (hpb_wr_en),
        .rcb_wr_done   (rcb_wr_done),
        .sched_starve  (sched_starve),
        .sched_busy    (sched_busy),
        .sched_wr_count(sched_wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_data(input int i);
        return 64'hD0D0_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [7:0] mk_be(input int i);
        return 8'h80 | 8'(i);
    endfunction

    // Present one write and hold valid until it is accepted
    task automatic push_one(input logic [13:0] a, input logic [63:0] d, input logic [7:0] be);
        int n;
        n = 0;
        host_wr_valid = 1'b1;
        host_wr_addr  = a;
        host_wr_data  = d;
        host_wr_be    = be;
        while (!host_wr_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check_eq("push_timeout", 64'(host_wr_ready), 64'd1);
        tick();
        host_wr_valid = 1'b0;
    endtask

    // Wait for a request, return the cycle it was first seen
    task automatic wait_req(output int rise);
        int n;
        n = 0;
        while (hpb_wr_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check_eq("req_seen", 64'(hpb_wr_req), 64'd1);
        rise = cyc;
    endtask

    // Act as RAM block: accept in first REQ cycle, done one cycle later
    task automatic serve(input logic [13:0] a, input logic [63:0] d, input logic [7:0] be,
                         output int rise);
        wait_req(rise);
        check_eq("serve_addr", 64'(hpb_wr_addr), 64'(a));
        check_eq("serve_data", hpb_wr_data, d);
        check_eq("serve_be", 64'(hpb_wr_en), 64'(be));
        tick();
        check_eq("req_hold", 64'(hpb_wr_req), 64'd1);
        rcb_wr_done = 1'b1;
        tick();
        rcb_wr_done = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check_eq("req_drop", 64'(hpb_wr_req), 64'd0);
        check_eq("wr_count", 64'(sched_wr_count), 64'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int prev;
        reset         = 1'b1;
        host_wr_valid = 1'b0;
        host_wr_addr  = '0;
        host_wr_data  = '0;
        host_wr_be    = '0;
        rcb_wr_done   = 1'b0;
        exp_cnt       = 16'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check_eq("rst_req", 64'(hpb_wr_req), 64'd0);
        check_eq("rst_addr", 64'(hpb_wr_addr), 64'd0);
        check_eq("rst_starve", 64'(sched_starve), 64'd0);
        check_eq("rst_busy", 64'(sched_busy), 64'd0);
        check_eq("rst_count", 64'(sched_wr_count), 64'd0);
        check_eq("rst_ready", 64'(host_wr_ready), 64'd1);

        // Single write with exact cycle timing
        host_wr_valid = 1'b1;
        host_wr_addr  = 14'h0012;
        host_wr_data  = 64'h1122_3344_5566_7788;
        host_wr_be    = 8'hFF;
        tick();
        host_wr_valid = 1'b0;
        check_eq("single_no_fallthru", 64'(hpb_wr_req), 64'd0);
        check_eq("single_busy", 64'(sched_busy), 64'd1);
        tick();
        check_eq("single_req1", 64'(hpb_wr_req), 64'd1);
        check_eq("single_addr", 64'(hpb_wr_addr), 64'h12);
        check_eq("single_data", hpb_wr_data, 64'h1122_3344_5566_7788);
        check_eq("single_en", 64'(hpb_wr_en), 64'hFF);
        tick();
        check_eq("single_req2", 64'(hpb_wr_req), 64'd1);
        rcb_wr_done = 1'b1;
        tick();
        rcb_wr_done = 1'b0;
        exp_cnt = 16'd1;
        check_eq("single_gap_req", 64'(hpb_wr_req), 64'd0);
        check_eq("single_count", 64'(sched_wr_count), 64'd1);
        tick();
        check_eq("single_idle_req", 64'(hpb_wr_req), 64'd0);
        check_eq("single_busy_fall", 64'(sched_busy), 64'd0);
        check_eq("single_addr_kept", 64'(hpb_wr_addr), 64'h12);

        // Spurious done while idle
        rcb_wr_done = 1'b1;
        tick();
        rcb_wr_done = 1'b0;
        tick();
        check_eq("spur_count", 64'(sched_wr_count), 64'd1);
        check_eq("spur_req", 64'(hpb_wr_req), 64'd0);
        check_eq("spur_busy", 64'(sched_busy), 64'd0);

        // FIFO full: five accepted with done withheld, sixth stalls
        for (int i = 0; i < 5; i++) begin
            check_eq("fill_ready", 64'(host_wr_ready), 64'd1);
            host_wr_valid = 1'b1;
            host_wr_addr  = 14'h100 + 14'(i);
            host_wr_data  = mk_data(i);
            host_wr_be    = mk_be(i);
            tick();
        end
        check_eq("full_ready", 64'(host_wr_ready), 64'd0);
        host_wr_addr = 14'h1FF;
        tick();
        tick();
        check_eq("stall_ready", 64'(host_wr_ready), 64'd0);
        host_wr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            serve(14'h100 + 14'(i), mk_data(i), mk_be(i), r);
        end
        tick();
        tick();
        check_eq("drain_busy", 64'(sched_busy), 64'd0);
        check_eq("drain_req", 64'(hpb_wr_req), 64'd0);

        // Back-to-back throughput: eight writes, request rises 4 cycles apart
        prev = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    push_one(14'h200 + 14'(i), mk_data(16 + i), mk_be(16 + i));
                end
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    serve(14'h200 + 14'(i), mk_data(16 + i), mk_be(16 + i), r);
                    if (i > 0) check_eq("b2b_spacing", 64'(r - prev), 64'd4);
                    prev = r;
                end
            end
        join
        check_eq("b2b_count", 64'(sched_wr_count), 64'd14);
        tick();
        check_eq("b2b_busy", 64'(sched_busy), 64'd0);

        // Starvation: done withheld 40 REQ cycles
        push_one(14'h0333, mk_data(99), 8'h3C);
        wait_req(r);
        for (int k = 1; k <= 40; k++) begin
            if (k == 32) check_eq("starve_early", 64'(sched_starve), 64'd0);
            if (k == 34) check_eq("starve_set", 64'(sched_starve), 64'd1);
            if (k == 40) check_eq("starve_hold", 64'(sched_starve), 64'd1);
            tick();
        end
        check_eq("starve_req", 64'(hpb_wr_req), 64'd1);
        check_eq("starve_addr", 64'(hpb_wr_addr), 64'h333);
        rcb_wr_done = 1'b1;
        tick();
        rcb_wr_done = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check_eq("starve_clear", 64'(sched_starve), 64'd0);
        check_eq("starve_count", 64'(sched_wr_count), 64'(exp_cnt));
        tick();

        // Reset during REQ with two entries queued
        push_one(14'h0401, mk_data(1), 8'h01);
        push_one(14'h0402, mk_data(2), 8'h02);
        push_one(14'h0403, mk_data(3), 8'h03);
        check_eq("mid_req", 64'(hpb_wr_req), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = 16'd0;
        check_eq("mid_rst_req", 64'(hpb_wr_req), 64'd0);
        check_eq("mid_rst_busy", 64'(sched_busy), 64'd0);
        check_eq("mid_rst_count", 64'(sched_wr_count), 64'd0);
        check_eq("mid_rst_ready", 64'(host_wr_ready), 64'd1);
        check_eq("mid_rst_addr", 64'(hpb_wr_addr), 64'd0);
        tick();
        check_eq("mid_rst_idle", 64'(hpb_wr_req), 64'd0);
        push_one(14'h0ABC, mk_data(7), 8'hA5);
        serve(14'h0ABC, mk_data(7), 8'hA5, r);
        tick();
        check_eq("post_rst_busy", 64'(sched_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
